// File: rtl/vga_scan_feeder.sv
// vga_scan_feeder: free-running VGA scan counters with a pixel pacer that pulls
// RGB565 beats from an upstream valid/ready stream. The pacer keeps the stream
// locked to scan position (0,0) and re-locks it after underrun or misalignment.
// Outputs leave through one register stage so position, colour and
// frame_start always stay aligned.
module vga_scan_feeder #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter logic [15:0] UNDERRUN_COLOUR = 16'h0000
) (
  input  logic        clk25,
  input  logic        rst,
  input  logic [15:0] pix_data_in,
  input  logic        pix_sof_in,
  input  logic        pix_valid_in,
  output logic        pix_ready_out,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [15:0] pixel_out,
  output logic        frame_start,
  output logic        locked,
  output logic [15:0] underrun_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {RESYNC, WAIT_FRAME, SYNCED} state_t;

  state_t      state_q, state_d;
  logic [9:0]  cnt_x_q, cnt_x_d;
  logic [9:0]  cnt_y_q, cnt_y_d;
  logic [9:0]  pixel_x_q, pixel_y_q;
  logic [15:0] pixel_out_q, pixel_out_d;
  logic        frame_start_q;
  logic [15:0] underrun_count_q, underrun_count_d;
  logic        vis, origin, frame_end, emit_underrun, ready;

  // Scan position: x wraps at the end of each line and advances y.
  always_comb begin
    vis       = (cnt_x_q < H_VIS) && (cnt_y_q < V_VIS);
    origin    = (cnt_x_q == 10'd0) && (cnt_y_q == 10'd0);
    frame_end = (cnt_x_q == H_LAST) && (cnt_y_q == V_LAST);
    cnt_x_d   = cnt_x_q + 10'd1;
    cnt_y_d   = cnt_y_q;
    if (cnt_x_q == H_LAST) begin
      cnt_x_d = 10'd0;
      cnt_y_d = (cnt_y_q == V_LAST) ? 10'd0 : cnt_y_q + 10'd1;
    end
  end

  // Lock FSM: picks the colour for this position, paces the stream and detects
  // SOF misalignment. A beat whose SOF flag disagrees with the origin flag is
  // never accepted in SYNCED, so the offending beat is left for RESYNC to drain
  // or for the next frame start to consume.
  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    pixel_out_d   = 16'h0000;
    emit_underrun = 1'b0;
    case (state_q)
      RESYNC: begin
        ready         = !(pix_valid_in && pix_sof_in);
        emit_underrun = vis;
        if (pix_valid_in && pix_sof_in) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        emit_underrun = vis;
        if (frame_end) state_d = SYNCED;
      end
      SYNCED: begin
        if (vis) begin
          ready = !(pix_valid_in && (pix_sof_in != origin));
          if (pix_valid_in && (pix_sof_in == origin)) begin
            pixel_out_d = pix_data_in;
          end else begin
            emit_underrun = 1'b1;
            if (pix_valid_in && origin)      state_d = RESYNC;
            else if (pix_valid_in)           state_d = WAIT_FRAME;
          end
        end
      end
      default: state_d = RESYNC;
    endcase
    if (emit_underrun) pixel_out_d = UNDERRUN_COLOUR;
    underrun_count_d = underrun_count_q;
    if (emit_underrun && (underrun_count_q != 16'hFFFF))
      underrun_count_d = underrun_count_q + 16'd1;
  end

  // Counters, FSM state and the single aligned output register stage.
  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q          <= RESYNC;
      cnt_x_q          <= 10'd0;
      cnt_y_q          <= 10'd0;
      pixel_x_q        <= 10'd0;
      pixel_y_q        <= 10'd0;
      pixel_out_q      <= 16'h0000;
      frame_start_q    <= 1'b0;
      underrun_count_q <= 16'h0000;
    end else begin
      state_q          <= state_d;
      cnt_x_q          <= cnt_x_d;
      cnt_y_q          <= cnt_y_d;
      pixel_x_q        <= cnt_x_q;
      pixel_y_q        <= cnt_y_q;
      pixel_out_q      <= pixel_out_d;
      frame_start_q    <= origin;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign pix_ready_out  = ready;
  assign pixel_x        = pixel_x_q;
  assign pixel_y        = pixel_y_q;
  assign pixel_out      = pixel_out_q;
  assign frame_start    = frame_start_q;
  assign locked         = (state_q == SYNCED);
  assign underrun_count = underrun_count_q;

endmodule
